// File: rtl/branch_table_maintenance_controller_pkg.sv
// Shared types for the branch-predictor table maintenance controller.
// Holds the sweep/idle state encoding and the width of the target RAM data.
package branch_table_maintenance_controller_pkg;

  localparam int TARGET_W = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } btm_state_t;

endpackage

// File: rtl/branch_table_maintenance_controller_fifo.sv
// Generic synchronous FIFO holding any packed type; push is refused when full, even while popping.
// Zero-latency head: data_out shows the oldest entry combinationally; clear empties it in one cycle.
module cva5_fifo #(
  parameter type DATA_TYPE = logic,
  parameter int  DEPTH     = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     push,
  input  logic     pop,
  input  DATA_TYPE data_in,
  output DATA_TYPE data_out,
  output logic     empty,
  output logic     full
);

  localparam int PW = $clog2(DEPTH);

  DATA_TYPE       mem [DEPTH];
  logic [PW:0]    wr_ptr;
  logic [PW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= data_in;
  end

  assign data_out = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/branch_table_maintenance_controller.sv
// Owns the predictor tag/target RAM write ports: invalidation sweeps, single-entry invalidates, queued updates.
// One RAM write per cycle; updates land one cycle after acceptance at the earliest; upd_ready drops only when the queue is full.
module branch_table_maintenance_controller
  import branch_table_maintenance_controller_pkg::*;
#(
  parameter  int ENTRIES           = 512,
  parameter  int WAYS              = 2,
  parameter  int ENTRY_W           = 24,
  parameter  int UPDATE_FIFO_DEPTH = 4,
  localparam int ADDR_W            = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                busy,
  output logic                prediction_enable,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [ADDR_W-1:0]   upd_addr,
  input  logic [WAYS-1:0]     upd_way,
  input  logic                upd_target_en,
  input  logic [ENTRY_W-1:0]  upd_entry,
  input  logic [TARGET_W-1:0] upd_target,
  input  logic                inval_valid,
  input  logic [ADDR_W-1:0]   inval_addr,
  input  logic [WAYS-1:0]     inval_way,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [WAYS-1:0]     ram_we_tag,
  output logic [WAYS-1:0]     ram_we_target,
  output logic [ENTRY_W-1:0]  ram_tag_data,
  output logic [TARGET_W-1:0] ram_target_data
);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [WAYS-1:0]     way;
    logic                target_en;
    logic [ENTRY_W-1:0]  entry;
    logic [TARGET_W-1:0] target;
  } bp_update_t;

  btm_state_t        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              flush_done_q;

  bp_update_t fifo_in;
  bp_update_t fifo_head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_clear;
  logic       idle_active;

  // IDLE cycles without a flush are the only ones that touch the queue or issue non-sweep writes.
  assign idle_active = (state_q == IDLE) && !flush_req;

  assign fifo_in    = '{addr: upd_addr, way: upd_way, target_en: upd_target_en,
                        entry: upd_entry, target: upd_target};
  assign fifo_push  = idle_active && upd_valid && !fifo_full;
  assign fifo_pop   = idle_active && !inval_valid && !fifo_empty;
  assign fifo_clear = (state_q == IDLE) && flush_req;

  cva5_fifo #(
    .DATA_TYPE (bp_update_t),
    .DEPTH     (UPDATE_FIFO_DEPTH)
  ) u_update_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (fifo_clear),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .data_in  (fifo_in),
    .data_out (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          if (flush_req) begin
            cnt_q <= '0;
          end else if (cnt_q == ADDR_W'(ENTRIES - 1)) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            flush_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (flush_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy              = (state_q == CLEAR);
  assign prediction_enable = ~busy;
  assign flush_done        = flush_done_q;
  // Sweeps and flushes swallow updates so the producer never stalls on a table that is being wiped.
  assign upd_ready         = busy || flush_req || !fifo_full;

  always_comb begin
    ram_addr        = '0;
    ram_we_tag      = '0;
    ram_we_target   = '0;
    ram_tag_data    = '0;
    ram_target_data = '0;
    if (state_q == CLEAR) begin
      ram_addr   = cnt_q;
      ram_we_tag = '1;
    end else if (idle_active) begin
      if (inval_valid) begin
        ram_addr   = inval_addr;
        ram_we_tag = inval_way;
      end else if (!fifo_empty) begin
        ram_addr     = fifo_head.addr;
        ram_we_tag   = fifo_head.way;
        ram_tag_data = fifo_head.entry;
        if (fifo_head.target_en) begin
          ram_we_target   = fifo_head.way;
          ram_target_data = fifo_head.target;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_table_maintenance_controller.sv
// Randomized and directed bench for the table maintenance controller against a queue-based reference model.
module tb_branch_table_maintenance_controller;

  localparam int ENTRIES = 8;
  localparam int WAYS    = 2;
  localparam int ENTRY_W = 24;
  localparam int DEPTH   = 4;
  localparam int AW      = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush_req;
  logic               flush_done;
  logic               busy;
  logic               prediction_enable;
  logic               upd_valid;
  logic               upd_ready;
  logic [AW-1:0]      upd_addr;
  logic [WAYS-1:0]    upd_way;
  logic               upd_target_en;
  logic [ENTRY_W-1:0] upd_entry;
  logic [31:0]        upd_target;
  logic               inval_valid;
  logic [AW-1:0]      inval_addr;
  logic [WAYS-1:0]    inval_way;
  logic [AW-1:0]      ram_addr;
  logic [WAYS-1:0]    ram_we_tag;
  logic [WAYS-1:0]    ram_we_target;
  logic [ENTRY_W-1:0] ram_tag_data;
  logic [31:0]        ram_target_data;

  always #5 clk = ~clk;

  branch_table_maintenance_controller #(
    .ENTRIES(ENTRIES), .WAYS(WAYS), .ENTRY_W(ENTRY_W), .UPDATE_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .prediction_enable(prediction_enable), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_addr(upd_addr), .upd_way(upd_way), .upd_target_en(upd_target_en),
    .upd_entry(upd_entry), .upd_target(upd_target), .inval_valid(inval_valid),
    .inval_addr(inval_addr), .inval_way(inval_way), .ram_addr(ram_addr),
    .ram_we_tag(ram_we_tag), .ram_we_target(ram_we_target), .ram_tag_data(ram_tag_data),
    .ram_target_data(ram_target_data)
  );

  typedef struct {
    logic [AW-1:0]      addr;
    logic [WAYS-1:0]    way;
    logic               ten;
    logic [ENTRY_W-1:0] entry;
    logic [31:0]        target;
  } upd_rec_t;

  // Reference model: a pending-update list plus a sweep position.
  upd_rec_t pending[$];
  bit       m_sweeping;
  int       m_pos;
  bit       m_done_next;
  int       done_pulses;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pending.delete();
    m_sweeping  = 1'b1;
    m_pos       = 0;
    m_done_next = 1'b0;
  endtask

  task automatic quiet();
    flush_req     = 1'b0;
    upd_valid     = 1'b0;
    upd_addr      = '0;
    upd_way       = '0;
    upd_target_en = 1'b0;
    upd_entry     = '0;
    upd_target    = '0;
    inval_valid   = 1'b0;
    inval_addr    = '0;
    inval_way     = '0;
  endtask

  task automatic rand_update();
    upd_valid     = 1'b1;
    upd_addr      = AW'($urandom_range(0, ENTRIES - 1));
    upd_way       = WAYS'(1 << $urandom_range(0, WAYS - 1));
    upd_target_en = 1'($urandom_range(0, 1));
    upd_entry     = ENTRY_W'($urandom);
    upd_target    = $urandom;
  endtask

  // Inputs are already driven for this cycle; compare outputs, then advance model and clock.
  task automatic cycle(input bit in_reset);
    logic [AW-1:0]      e_addr;
    logic [WAYS-1:0]    e_wt, e_wg;
    logic [ENTRY_W-1:0] e_td;
    logic [31:0]        e_tg;
    logic               e_rdy;
    upd_rec_t           r;
    bit                 do_pop;
    #2;
    e_addr = '0; e_wt = '0; e_wg = '0; e_td = '0; e_tg = '0; do_pop = 1'b0;
    if (m_sweeping) begin
      e_addr = AW'(m_pos);
      e_wt   = '1;
      e_rdy  = 1'b1;
    end else begin
      e_rdy = flush_req || (pending.size() < DEPTH);
      if (!flush_req) begin
        if (inval_valid) begin
          e_addr = inval_addr;
          e_wt   = inval_way;
        end else if (pending.size() > 0) begin
          r      = pending[0];
          do_pop = 1'b1;
          e_addr = r.addr;
          e_wt   = r.way;
          e_td   = r.entry;
          if (r.ten) begin
            e_wg = r.way;
            e_tg = r.target;
          end
        end
      end
    end
    check("ram_we_tag", 32'(ram_we_tag), 32'(e_wt));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_we_target", 32'(ram_we_target), 32'(e_wg));
    check("ram_tag_data", 32'(ram_tag_data), 32'(e_td));
    check("ram_target_data", ram_target_data, e_tg);
    check("upd_ready", 32'(upd_ready), 32'(e_rdy));
    check("busy", 32'(busy), 32'(m_sweeping));
    check("prediction_enable", 32'(prediction_enable), 32'(!m_sweeping));
    check("flush_done", 32'(flush_done), 32'(m_done_next));
    if (flush_done) done_pulses++;
    if (!in_reset) begin
      if (m_sweeping) begin
        m_done_next = 1'b0;
        if (flush_req) m_pos = 0;
        else if (m_pos == ENTRIES - 1) begin
          m_sweeping  = 1'b0;
          m_done_next = 1'b1;
        end else m_pos++;
      end else begin
        m_done_next = 1'b0;
        if (flush_req) begin
          pending.delete();
          m_sweeping = 1'b1;
          m_pos      = 0;
        end else begin
          if (do_pop) void'(pending.pop_front());
          if (upd_valid && e_rdy) begin
            r = '{upd_addr, upd_way, upd_target_en, upd_entry, upd_target};
            pending.push_back(r);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b0;
    model_reset();
    cycle(1'b1);
    cycle(1'b1);
    rst = 1'b1;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    #1;
    do_reset();

    // Power-up sweep followed by the completion pulse.
    done_pulses = 0;
    repeat (ENTRIES + 1) cycle(1'b0);
    check("sweep_done_count", 32'(done_pulses), 32'd1);

    // Single update with target write.
    upd_valid = 1'b1; upd_addr = 3'd5; upd_way = 2'b10; upd_target_en = 1'b1;
    upd_entry = 24'h8a5a5a; upd_target = 32'h8000_0040;
    cycle(1'b0);
    quiet();
    repeat (2) cycle(1'b0);

    // Invalidates hold off the drain while updates fill the queue.
    for (int i = 0; i < 6; i++) begin
      inval_valid = 1'b1; inval_addr = AW'(i); inval_way = 2'b01;
      rand_update();
      cycle(1'b0);
    end
    quiet();
    repeat (6) cycle(1'b0);

    // Flush discards three queued updates.
    for (int i = 0; i < 3; i++) begin
      inval_valid = 1'b1; inval_addr = AW'(7 - i); inval_way = 2'b10;
      rand_update();
      cycle(1'b0);
    end
    quiet();
    flush_req = 1'b1;
    cycle(1'b0);
    flush_req = 1'b0;
    done_pulses = 0;
    repeat (ENTRIES + 1) cycle(1'b0);
    check("flush_done_count", 32'(done_pulses), 32'd1);

    // Restarted sweep at counter 4 yields one pulse after a full sweep.
    flush_req = 1'b1;
    cycle(1'b0);
    flush_req = 1'b0;
    done_pulses = 0;
    repeat (4) cycle(1'b0);
    flush_req = 1'b1;
    cycle(1'b0);
    flush_req = 1'b0;
    repeat (ENTRIES + 1) cycle(1'b0);
    check("restart_done_count", 32'(done_pulses), 32'd1);

    // Same-cycle flush and update: update dropped.
    flush_req = 1'b1;
    rand_update();
    cycle(1'b0);
    quiet();
    repeat (ENTRIES + 2) cycle(1'b0);

    // Randomized traffic with one reset mid-run.
    for (int i = 0; i < 1500; i++) begin
      quiet();
      if (i == 700) do_reset();
      flush_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) rand_update();
      if ($urandom_range(0, 9) < 3) begin
        inval_valid = 1'b1;
        inval_addr  = AW'($urandom_range(0, ENTRIES - 1));
        inval_way   = WAYS'(1 << $urandom_range(0, WAYS - 1));
      end
      cycle(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_table_maintenance_controller.md
# branch_table_maintenance_controller

Owns the write ports of the branch-predictor tag and target RAMs. It sequences the full-table invalidation sweep after reset and on flush requests, such as fence.i or an address-space change. It queues execute-stage update requests and arbitrates them against single-entry invalidations. It sits between branch-unit result logic and the per-way predictor RAM banks, and it gates fetch-side prediction use while the tables are not coherent.

## Interface
Parameters:
- ENTRIES, 512, entries per way; power of two, ≥2; ADDR_W = $clog2(ENTRIES)
- WAYS, 2, number of ways; ≥1
- ENTRY_W, 24, width of the packed tag-table entry; bit ENTRY_W-1 is the valid bit
- UPDATE_FIFO_DEPTH, 4, depth of the update queue; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- flush_req  in  1  request invalidation of every entry in every way
- flush_done  out  1  one-cycle pulse when a sweep completes
- busy  out  1  sweep in progress
- prediction_enable  out  1  equals ~busy; fetch must ignore predictor hits when low
- upd_valid  in  1  execute-stage update request
- upd_ready  out  1  update accepted this cycle when high with upd_valid
- upd_addr  in  ADDR_W  table index
- upd_way  in  WAYS  one-hot target way
- upd_target_en  in  1  also write the target RAM
- upd_entry  in  ENTRY_W  tag-table data
- upd_target  in  32  target PC
- inval_valid  in  1  single-entry invalidate; no handshake
- inval_addr  in  ADDR_W  index
- inval_way  in  WAYS  one-hot way
- ram_addr  out  ADDR_W  shared write address, all banks
- ram_we_tag  out  WAYS  per-way tag write enable
- ram_we_target  out  WAYS  per-way target write enable
- ram_tag_data  out  ENTRY_W  tag write data
- ram_target_data  out  32  target write data

## Operation
- FSM states: CLEAR and IDLE.
- Reset enters CLEAR with sweep counter 0 and the FIFO empty.
- CLEAR:
  - Each cycle: ram_addr = counter; ram_we_tag = all ones; ram_tag_data = 0; ram_we_target = 0.
  - Counter increments each cycle.
  - At counter = ENTRIES-1, go to IDLE and register a flush_done pulse, so the pulse is high in the first IDLE cycle.
- flush_req in CLEAR: counter restarts at 0. Only the final completed sweep pulses flush_done.
- In CLEAR, upd_valid is acked (upd_ready = 1) and dropped. inval_valid is ignored.
- IDLE write priority, exactly one write per cycle:
  1. flush_req: FIFO cleared, go to CLEAR with counter 0, no RAM write this cycle. A same-cycle update is acked and dropped.
  2. inval_valid: ram_we_tag = inval_way, ram_tag_data = 0, addr = inval_addr. The FIFO does not pop.
  3. FIFO not empty: pop the head. ram_we_tag = head.way. ram_we_target = head.way when head.target_en, else 0.
- upd_ready in IDLE = FIFO not full. No bypass: push and pop in the same cycle are allowed, but a full FIFO never accepts, even while popping.
- All RAM outputs are combinational from the state, counter, and FIFO head. Data outputs are 0 when no enable is asserted.

## Timing
- Reset values:
  - busy = 1, prediction_enable = 0, flush_done = 0, upd_ready = 1
  - ram_we_tag = all ones, ram_addr = 0, ram_tag_data = 0
  - ram_we_target = 0, ram_target_data = 0
- Sweep length: ENTRIES cycles from the reset release, or from the cycle after flush_req is sampled.
- Update latency: an update accepted in cycle N is written in cycle N+1 at the earliest. Each inval cycle and each older queued entry adds one cycle.
- An asserted rst mid-sweep or mid-drain discards all state and restarts in CLEAR.

## Structure
- bp_update_t (addr, way, target_en, entry, target) belongs in the shared cva5_types package.
- The update queue is an instance of the existing cva5_fifo, with DATA_TYPE bp_update_t and DEPTH UPDATE_FIFO_DEPTH.
- FSM, counter, and arbiter stay in this module.

## Test plan
- Reset release with ENTRIES = 8, WAYS = 2 -> 8 cycles with ram_we_tag = 2'b11 and addr 0..7, then flush_done pulses once and prediction_enable rises.
- Update in IDLE: addr 5, way 2'b10, target_en 1, target 0x8000_0040 -> next cycle ram_we_tag = 2'b10, ram_we_target = 2'b10, ram_addr = 5, ram_target_data = 0x8000_0040.
- Hold inval_valid 6 cycles while streaming updates, DEPTH 4 -> upd_ready falls after 4 accepts; queued writes then emerge in order with no loss.
- flush_req with 3 queued updates -> none is written; sweep covers addrs 0..7; flush_done 8 cycles later.
- flush_req again at counter 4 -> counter returns to 0; one flush_done only, after a full 8-cycle sweep.
- Same-cycle flush_req and upd_valid in IDLE -> upd_ready = 1, update never written, sweep begins.
